if_stage: RTL and testbench

Instruction fetch stage of the 5-stage pipeline. It generates sequential fetch addresses, drives the instruction-memory request/grant/response handshake, and buffers returned words in a small prefetch FIFO. It presents one instruction per cycle, with its PC, to the decode stage through the IF/ID register. EX-stage redirects (taken branch or jump) flush everything in flight and restart fetch at the target.

---
 rtl/if_stage.sv | 145 ++++++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: bus handshake, prefetch FIFO, IF/ID register
// One outstanding transaction; the credit check keeps the FIFO from ever overflowing.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_id_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] pc_id_o,
  output logic        fetch_err_id_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, req_addr_q, out_pc_q;
  logic          discard_q;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic          fifo_err  [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;

  logic [31:0] target;
  logic        in_wait, in_req, ok, resp_ok, resp_acc, comb_req, grant;
  logic        fifo_empty, load_ok, bypass, push, pop;

  assign target   = {redirect_pc_i[31:2], 2'b00};
  assign in_wait  = (state_q == S_WAIT);
  assign in_req   = (state_q == S_REQ);
  assign ok       = (CW'(count_q) + CW'(in_wait)) < CW'(FIFO_DEPTH);
  assign resp_ok  = in_wait & instr_rvalid_i;
  assign resp_acc = resp_ok & ~discard_q & ~redirect_i;
  // Back-to-back request in the response cycle; suppressed on redirect so the old PC is never issued.
  assign comb_req = resp_ok & ok & ~redirect_i;

  assign instr_req_o  = in_req | comb_req;
  assign instr_addr_o = in_req ? req_addr_q : fetch_pc_q;
  assign grant        = instr_req_o & instr_gnt_i;

  assign fifo_empty = (count_q == '0);
  assign load_ok    = ~redirect_i & ~stall_id_i;
  assign bypass     = resp_acc & fifo_empty & load_ok;
  assign push       = resp_acc & ~bypass;
  assign pop        = load_ok & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (redirect_i || ok) state_d = S_REQ;
      S_REQ:  if (instr_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (instr_rvalid_i) begin
          if (grant)                 state_d = S_WAIT;
          else if (redirect_i || ok) state_d = S_REQ;
          else                       state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_addr_q <= BOOT_ADDR;
      out_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!in_req && state_d == S_REQ) req_addr_q <= redirect_i ? target : fetch_pc_q;
      if (grant) out_pc_q <= instr_addr_o;
      // A stale request (discard set while in REQ) does not advance the fetch PC when granted.
      if (redirect_i) fetch_pc_q <= target;
      else if (grant && !(in_req && discard_q)) fetch_pc_q <= fetch_pc_q + 32'd4;
      if (redirect_i) discard_q <= in_req | (in_wait & ~instr_rvalid_i);
      else if (resp_ok) discard_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wr_ptr_q]   <= out_pc_q;
      fifo_data[wr_ptr_q] <= instr_rdata_i;
      fifo_err[wr_ptr_q]  <= instr_err_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_valid_id_o <= 1'b0;
      instr_rdata_id_o <= 32'h0000_0013;
      pc_id_o          <= '0;
      fetch_err_id_o   <= 1'b0;
    end else if (redirect_i) begin
      instr_valid_id_o <= 1'b0;
    end else if (!stall_id_i) begin
      if (!fifo_empty) begin
        instr_valid_id_o <= 1'b1;
        pc_id_o          <= fifo_pc[rd_ptr_q];
        instr_rdata_id_o <= fifo_data[rd_ptr_q];
        fetch_err_id_o   <= fifo_err[rd_ptr_q];
      end else if (bypass) begin
        instr_valid_id_o <= 1'b1;
        pc_id_o          <= out_pc_q;
        instr_rdata_id_o <= instr_rdata_i;
        fetch_err_id_o   <= instr_err_i;
      end else begin
        instr_valid_id_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - bench for if_stage: directed scenarios plus random bus/stall/redirect traffic
// Memory and decode are modelled as a sequential-PC scoreboard over a word function of the address.
module tb_if_stage;
  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        redirect, stall;
  logic [31:0] redirect_pc;
  logic        valid_id, err_id;
  logic [31:0] rdata_id, pc_id;
  logic        gnt_en;

  assign instr_gnt = instr_req & gnt_en;

  if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_gnt_i(instr_gnt),
    .instr_rvalid_i(instr_rvalid), .instr_rdata_i(instr_rdata), .instr_err_i(instr_err),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_id_i(stall),
    .instr_valid_id_o(valid_id), .instr_rdata_id_o(rdata_id), .pc_id_o(pc_id),
    .fetch_err_id_o(err_id)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0, consumed = 0;
  logic        gnt_en_v, stall_v, redir_v;
  logic [31:0] redir_pc_v;
  int          resp_lat;
  logic        pend_v;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] exp_pc, err_addr;
  logic        err_rand;
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;
  logic        s_req, s_gnt, s_valid, s_err;
  logic [31:0] s_addr, s_pc, s_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0013_0000;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_addr) || (err_rand && a[6:2] == 5'd13);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    instr_rvalid = 1'b0;
    instr_err    = 1'b0;
    instr_rdata  = $urandom;
    if (pend_v && pend_cnt == 0) begin
      instr_rvalid = 1'b1;
      instr_rdata  = mem_word(pend_addr);
      instr_err    = mem_err(pend_addr);
    end
    stall       = stall_v;
    redirect    = redir_v;
    redirect_pc = redir_pc_v;
    gnt_en      = gnt_en_v;
    #1;
    s_req = instr_req; s_addr = instr_addr; s_gnt = instr_req & gnt_en;
    s_valid = valid_id; s_pc = pc_id; s_data = rdata_id; s_err = err_id;
    if (prev_req && !prev_gnt) begin
      chk("req_hold", 32'(s_req), 32'd1);
      chk("addr_hold", s_addr, prev_addr);
    end
    if (s_valid && !stall && !redirect) begin
      chk("pc_seq", s_pc, exp_pc);
      chk("rdata", s_data, mem_word(exp_pc));
      chk("err_flag", 32'(s_err), 32'(mem_err(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    @(posedge clk);
    if (instr_rvalid) pend_v = 1'b0;
    else if (pend_v) pend_cnt--;
    if (s_gnt) begin
      chk("one_outstanding", 32'(pend_v), 32'd0);
      pend_v = 1'b1; pend_addr = s_addr; pend_cnt = resp_lat;
    end
    if (redirect) exp_pc = redirect_pc & ~32'd3;
    prev_req = s_req; prev_gnt = s_gnt; prev_addr = s_addr;
  endtask

  initial begin
    int n;
    int c0;
    logic [31:0] a_hold;
    rst_n = 1'b0; instr_rvalid = 1'b0; instr_err = 1'b0; instr_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0; gnt_en = 1'b0;
    gnt_en_v = 1'b0; stall_v = 1'b0; redir_v = 1'b0; redir_pc_v = '0;
    resp_lat = 0; pend_v = 1'b0; pend_addr = '0; pend_cnt = 0;
    exp_pc = BOOT; err_addr = 32'h0000_0108; err_rand = 1'b0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(instr_req), 32'd0);
    chk("rst_addr", instr_addr, BOOT);
    chk("rst_valid", 32'(valid_id), 32'd0);
    chk("rst_rdata", rdata_id, 32'h0000_0013);
    chk("rst_pc", pc_id, 32'd0);
    chk("rst_err", 32'(err_id), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Boot on zero-wait memory
    gnt_en_v = 1'b1;
    cycle(); chk("c1_req", 32'(s_req), 32'd1); chk("c1_addr", s_addr, 32'h100);
    cycle(); chk("c2_addr", s_addr, 32'h104); chk("c2_valid", 32'(s_valid), 32'd0);
    cycle(); chk("c3_valid", 32'(s_valid), 32'd1); chk("c3_pc", s_pc, 32'h100);
    chk("c3_addr", s_addr, 32'h108);

    // Four-cycle decode stall, then the error word at 0x108
    stall_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_pc", s_pc, 32'h104);
      if (i >= 1) chk("stall_req_low", 32'(s_req), 32'd0);
    end
    stall_v = 1'b0;
    cycle(); chk("rel_pc", s_pc, 32'h104);
    cycle(); chk("err_pc", s_pc, 32'h108); chk("err_set", 32'(s_err), 32'd1);
    cycle(); chk("after_err_pc", s_pc, 32'h10C); chk("after_err_clr", 32'(s_err), 32'd0);

    // Redirect while a response is pending
    resp_lat = 2;
    n = 0;
    do begin cycle(); n++; end while (!s_gnt && n < 20);
    chk("wait_gnt_seen", 32'(s_gnt), 32'd1);
    redir_v = 1'b1; redir_pc_v = 32'h0000_0203;
    cycle();
    redir_v = 1'b0;
    cycle(); chk("redir_valid_drop", 32'(s_valid), 32'd0);
    n = 0;
    while (!s_req && n < 10) begin cycle(); n++; end
    chk("wait_redir_addr", s_addr, 32'h200);
    resp_lat = 0;
    n = 0;
    do begin cycle(); n++; end while (!s_valid && n < 12);
    chk("wait_redir_pc", s_pc, 32'h200);

    // Redirect in REQ with grant held low for three cycles
    repeat (3) cycle();
    gnt_en_v = 1'b0;
    cycle(); chk("req_stall_req", 32'(s_req), 32'd1);
    a_hold = s_addr;
    redir_v = 1'b1; redir_pc_v = 32'h0000_0200;
    cycle(); chk("req_hold_a", s_addr, a_hold);
    redir_v = 1'b0;
    cycle(); chk("req_hold_b", s_addr, a_hold);
    gnt_en_v = 1'b1;
    cycle(); chk("req_stale_gnt", s_addr, a_hold); chk("req_stale_gnt_seen", 32'(s_gnt), 32'd1);
    n = 0;
    do begin cycle(); n++; end while (!s_req && n < 10);
    chk("req_redir_addr", s_addr, 32'h200);
    n = 0;
    do begin cycle(); n++; end while (!s_valid && n < 12);
    chk("req_redir_pc", s_pc, 32'h200);

    // Wrap-around after redirect to the top word
    repeat (4) cycle();
    redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFC;
    cycle();
    redir_v = 1'b0;
    cycle(); chk("wrap_req", 32'(s_req), 32'd1); chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    chk("wrap_valid_drop", 32'(s_valid), 32'd0);
    cycle(); chk("wrap_addr_zero", s_addr, 32'h0);
    repeat (4) cycle();

    // Random traffic against the scoreboard
    err_rand = 1'b1;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      gnt_en_v   = ($urandom_range(0, 99) < 70);
      stall_v    = ($urandom_range(0, 99) < 25);
      redir_v    = ($urandom_range(0, 99) < 4);
      redir_pc_v = $urandom;
      resp_lat   = $urandom_range(0, 2);
      cycle();
    end
    chk("progress", 32'((consumed - c0) > 100), 32'd1);

    // Asynchronous reset with a response outstanding
    stall_v = 1'b0; redir_v = 1'b0; gnt_en_v = 1'b1; resp_lat = 2;
    n = 0;
    do begin cycle(); n++; end while (!s_gnt && n < 20);
    chk("gnt_before_reset", 32'(s_gnt), 32'd1);
    @(negedge clk);
    instr_rvalid = 1'b0; stall = 1'b0; redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(instr_req), 32'd0);
    chk("mid_rst_addr", instr_addr, BOOT);
    chk("mid_rst_valid", 32'(valid_id), 32'd0);
    chk("mid_rst_pc", pc_id, 32'd0);
    pend_cnt = 0; exp_pc = BOOT; prev_req = 1'b0; prev_gnt = 1'b0;
    gnt_en_v = 1'b0; gnt_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cycle();
    gnt_en_v = 1'b1; resp_lat = 0;
    n = 0;
    do begin cycle(); n++; end while (!s_valid && n < 10);
    chk("post_rst_first_pc", s_pc, BOOT);
    repeat (10) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
